// File: rtl/pipeline_control_sequencer.sv
// pipeline_control_sequencer
//   Consumer side of the hazard detection unit. It turns hazard stalls, EX-stage
//   branch flushes, data-memory waits and ecall-halt requests into per-stage write
//   enables, flushes and bubbles for the 5-stage pipeline. It also owns the
//   halt-drain FSM and the saturating performance counters.
//
//   State table:
//     state   | meaning
//     RUN     | normal execution; hazards resolved by priority
//     DRAIN   | fetch stopped, ecall and older instrs retiring
//     HALTED  | pipeline frozen, is_halted high; left only by reset
//
//   Ports:
//     clk, reset            rising-edge clock, synchronous active-high reset
//     is_stall              load-use / ecall hazard stall
//     branch_flush          EX-stage mispredict
//     mem_busy              data memory not ready; whole pipeline holds
//     halt_req              ID holds a halting ecall
//     pc_write .. mem_wb_write  per-stage write enables
//     if_id_flush           IF/ID loads a NOP
//     id_ex_bubble          ID/EX loads a NOP
//     is_halted             high in HALTED
//     stall_cycles, flush_count, mem_wait_cycles   saturating counters
module pipeline_control_sequencer #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 is_stall,
    input  logic                 branch_flush,
    input  logic                 mem_busy,
    input  logic                 halt_req,
    output logic                 pc_write,
    output logic                 if_id_write,
    output logic                 if_id_flush,
    output logic                 id_ex_write,
    output logic                 id_ex_bubble,
    output logic                 ex_mem_write,
    output logic                 mem_wb_write,
    output logic                 is_halted,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_count,
    output logic [CNT_WIDTH-1:0] mem_wait_cycles
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] drain_cnt, drain_cnt_nxt;
    logic          inc_stall, inc_flush, inc_mem;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_RUN;
            drain_cnt       <= '0;
            stall_cycles    <= '0;
            flush_count     <= '0;
            mem_wait_cycles <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
            if (inc_stall && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNT_WIDTH'(1);
            if (inc_flush && flush_count != '1)
                flush_count <= flush_count + CNT_WIDTH'(1);
            if (inc_mem && mem_wait_cycles != '1)
                mem_wait_cycles <= mem_wait_cycles + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_write  = 1'b1;
        mem_wb_write  = 1'b1;
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        inc_stall     = 1'b0;
        inc_flush     = 1'b0;
        inc_mem       = 1'b0;

        if (reset) begin
            // Hold every stage and load NOPs while reset is asserted.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else begin
            case (state)
                S_RUN: begin
                    if (mem_busy) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_write = 1'b0;
                        mem_wb_write = 1'b0;
                        inc_mem      = 1'b1;
                    end else if (branch_flush) begin
                        // Squashes the ID instr, so a stall or halt from it is moot.
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        inc_flush    = 1'b1;
                    end else if (is_stall) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        inc_stall    = 1'b1;
                    end else if (halt_req) begin
                        pc_write      = 1'b0;
                        if_id_flush   = 1'b1;
                        drain_cnt_nxt = DW'(DRAIN_CYCLES - 1);
                        state_nxt     = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (mem_busy) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_write = 1'b0;
                        mem_wb_write = 1'b0;
                        inc_mem      = 1'b1;
                    end else begin
                        pc_write    = 1'b0;
                        if_id_flush = 1'b1;
                        if (drain_cnt == '0)
                            state_nxt = S_HALTED;
                        else
                            drain_cnt_nxt = drain_cnt - DW'(1);
                    end
                end
                default: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_write = 1'b0;
                    mem_wb_write = 1'b0;
                end
            endcase
        end
    end

    assign is_halted = (state == S_HALTED);

endmodule

// File: tb/tb_pipeline_control_sequencer.sv
module tb_pipeline_control_sequencer;

    localparam int CW   = 8;
    localparam int DRN  = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset, is_stall, branch_flush, mem_busy, halt_req;
    logic          pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
    logic          ex_mem_write, mem_wb_write, is_halted;
    logic [CW-1:0] stall_cycles, flush_count, mem_wait_cycles;

    int checks   = 0;
    int failures = 0;

    // Reference model: halted flag, busy-free drain cycles still owed, plain counts.
    bit m_halted;
    int m_drain_left;
    int m_stall, m_flush, m_mem;

    pipeline_control_sequencer #(.DRAIN_CYCLES(DRN), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .is_stall(is_stall), .branch_flush(branch_flush),
        .mem_busy(mem_busy), .halt_req(halt_req), .pc_write(pc_write),
        .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_write(id_ex_write),
        .id_ex_bubble(id_ex_bubble), .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
        .is_halted(is_halted), .stall_cycles(stall_cycles), .flush_count(flush_count),
        .mem_wait_cycles(mem_wait_cycles)
    );

    always #5 clk = ~clk;

    // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write, mem_wb_write}
    function automatic logic [6:0] dut_vec();
        return {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
                ex_mem_write, mem_wb_write};
    endfunction

    function automatic logic [6:0] model_out();
        if (reset)                 return 7'b0010100;
        if (m_halted)              return 7'b0000000;
        if (mem_busy)              return 7'b0000000;
        if (m_drain_left > 0)      return 7'b0111011;
        if (branch_flush)          return 7'b1111111;
        if (is_stall)              return 7'b0001111;
        if (halt_req)              return 7'b0111011;
        return 7'b1101011;
    endfunction

    function automatic int sat_inc(int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Advance the model for the coming edge, then move to the next falling edge.
    task automatic tick();
        if (reset) begin
            m_halted = 0; m_drain_left = 0; m_stall = 0; m_flush = 0; m_mem = 0;
        end else if (!m_halted) begin
            if (mem_busy) m_mem = sat_inc(m_mem);
            else if (m_drain_left > 0) begin
                m_drain_left--;
                if (m_drain_left == 0) m_halted = 1;
            end else if (branch_flush) m_flush = sat_inc(m_flush);
            else if (is_stall) m_stall = sat_inc(m_stall);
            else if (halt_req) m_drain_left = DRN;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input bit mb, input bit bf, input bit st, input bit hr);
        mem_busy = mb; branch_flush = bf; is_stall = st; halt_req = hr;
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (dut_vec() !== 7'b0010100) begin
                failures++;
                $display("FAIL reset_outs cyc=%0d got=%b exp=%b", i, dut_vec(), 7'b0010100);
            end
            tick();
        end
        reset = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 7'b1101011 || is_halted !== 1'b0) begin
            failures++;
            $display("FAIL post_reset got=%b halted=%b exp=1101011 halted=0", dut_vec(), is_halted);
        end
        checks++;
        if (stall_cycles !== 0 || flush_count !== 0 || mem_wait_cycles !== 0) begin
            failures++;
            $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0",
                     stall_cycles, flush_count, mem_wait_cycles);
        end
    endtask

    task automatic test_stall();
        do_reset();
        drive(0, 0, 1, 0);
        checks++;
        if (dut_vec() !== 7'b0001111) begin
            failures++;
            $display("FAIL stall_outs got=%b exp=0001111", dut_vec());
        end
        tick();
        drive(0, 0, 0, 0);
        checks++;
        if (stall_cycles !== 8'd1) begin
            failures++;
            $display("FAIL stall_count got=%0d exp=1", stall_cycles);
        end
    endtask

    task automatic test_flush_over_stall();
        do_reset();
        drive(0, 1, 1, 1);
        checks++;
        if (dut_vec() !== 7'b1111111) begin
            failures++;
            $display("FAIL flush_outs got=%b exp=1111111", dut_vec());
        end
        tick();
        drive(0, 0, 0, 0);
        checks++;
        if (flush_count !== 8'd1 || stall_cycles !== 8'd0 || is_halted !== 1'b0) begin
            failures++;
            $display("FAIL flush_count got=%0d stall=%0d halted=%b exp=1 0 0",
                     flush_count, stall_cycles, is_halted);
        end
    endtask

    task automatic test_halt();
        do_reset();
        drive(0, 0, 0, 1);
        checks++;
        if (pc_write !== 1'b0 || if_id_flush !== 1'b1) begin
            failures++;
            $display("FAIL halt_accept pc_write=%b if_id_flush=%b exp=0 1", pc_write, if_id_flush);
        end
        tick();
        drive(0, 0, 0, 0);
        for (int n = 1; n <= 4; n++) begin
            checks++;
            if (pc_write !== 1'b0 || is_halted !== 1'b0) begin
                failures++;
                $display("FAIL halt_drain n=%0d pc_write=%b halted=%b exp=0 0", n, pc_write, is_halted);
            end
            tick();
            if (n == DRN) break;
        end
        for (int n = 0; n < 12; n++) begin
            drive(n[0], n[1], n[2], 1);
            checks++;
            if (is_halted !== 1'b1 || dut_vec() !== 7'b0000000) begin
                failures++;
                $display("FAIL halted_hold n=%0d halted=%b outs=%b exp=1 0000000", n, is_halted, dut_vec());
            end
            tick();
        end
        checks++;
        if (stall_cycles !== 0 || flush_count !== 0 || mem_wait_cycles !== 0) begin
            failures++;
            $display("FAIL halted_frozen got=%0d/%0d/%0d exp=0/0/0",
                     stall_cycles, flush_count, mem_wait_cycles);
        end
    endtask

    task automatic test_halt_mem_busy();
        int edges;
        do_reset();
        drive(0, 0, 0, 1);
        tick();
        edges = 0;
        while (is_halted !== 1'b1 && edges < 20) begin
            if (edges < 2) begin
                drive(1, 0, 0, 0);
                checks++;
                if (dut_vec() !== 7'b0000000) begin
                    failures++;
                    $display("FAIL drain_busy_outs e=%0d got=%b exp=0000000", edges, dut_vec());
                end
            end else drive(0, 0, 0, 0);
            tick();
            edges++;
        end
        checks++;
        if (edges != 5) begin
            failures++;
            $display("FAIL drain_busy_latency got=%0d exp=5", edges);
        end
        checks++;
        if (mem_wait_cycles !== 8'd2) begin
            failures++;
            $display("FAIL drain_busy_count got=%0d exp=2", mem_wait_cycles);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        drive(0, 0, 1, 0);
        for (int i = 0; i < CMAX + 10; i++) begin
            if (i == 100) begin
                checks++;
                if (stall_cycles !== 8'd100) begin
                    failures++;
                    $display("FAIL stall_mid got=%0d exp=100", stall_cycles);
                end
            end
            tick();
        end
        checks++;
        if (stall_cycles !== 8'hFF) begin
            failures++;
            $display("FAIL stall_saturate got=%0d exp=255", stall_cycles);
        end
        drive(0, 0, 0, 1);
        for (int i = 0; i < DRN + 1; i++) begin
            tick();
            drive(0, 0, 0, 0);
        end
        checks++;
        if (is_halted !== 1'b1 || stall_cycles !== 8'hFF) begin
            failures++;
            $display("FAIL sat_halt halted=%b stall=%0d exp=1 255", is_halted, stall_cycles);
        end
        do_reset();
        checks++;
        if (is_halted !== 1'b0 || stall_cycles !== 0 || dut_vec() !== 7'b1101011) begin
            failures++;
            $display("FAIL reset_from_halted halted=%b stall=%0d outs=%b exp=0 0 1101011",
                     is_halted, stall_cycles, dut_vec());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (m_halted && $urandom_range(0, 3) == 0) reset = 1'b1;
            else reset = 1'b0;
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0);
            checks++;
            if (dut_vec() !== model_out() || is_halted !== m_halted) begin
                failures++;
                $display("FAIL rand_outs i=%0d got=%b/%b exp=%b/%b", i, dut_vec(), is_halted,
                         model_out(), m_halted);
            end
            checks++;
            if (stall_cycles !== m_stall[CW-1:0] || flush_count !== m_flush[CW-1:0] ||
                mem_wait_cycles !== m_mem[CW-1:0]) begin
                failures++;
                $display("FAIL rand_counters i=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i,
                         stall_cycles, flush_count, mem_wait_cycles, m_stall, m_flush, m_mem);
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        is_stall = 1'b0; branch_flush = 1'b0; mem_busy = 1'b0; halt_req = 1'b0;
        m_halted = 0; m_drain_left = 0; m_stall = 0; m_flush = 0; m_mem = 0;
        @(negedge clk);
        test_reset();
        test_stall();
        test_flush_over_stall();
        test_halt();
        test_halt_mem_busy();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout exp=finish before 2000000");
        $fatal(1, "timeout");
    end

endmodule
